// File: rtl/gf_inv_16_s.sv
// GF(2^16) = GF(2^8)[X]/(X^2 + X + c) inverter.
// A single GF(2^8) multiplier is time-shared by the FSM: norm, N^254, then the two result halves.
module gf_inv_16_s #(
  parameter logic [7:0] IRRED_CST = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_x,
  output logic [15:0] o_o,
  output logic        o_done,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NRM0,
    S_NRM1,
    S_NRM2,
    S_EXP,
    S_OUT0,
    S_OUT1,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd14;

  state_t      state_q, state_d;
  logic [3:0]  step_q,  step_d;
  logic [7:0]  a0_q,    a0_d;
  logic [7:0]  a1_q,    a1_d;
  logic [7:0]  t0_q,    t0_d;
  logic [7:0]  t1_q,    t1_d;
  logic [7:0]  n_q,     n_d;
  logic [7:0]  acc_q,   acc_d;
  logic [15:0] o_q,     o_d;

  logic [7:0]  mul_a, mul_b, mul_p;

  // GF(2^8) product modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Operand selection: exactly one product per cycle.
  // In EXP, even steps square the accumulator and odd steps multiply it by N,
  // which walks the exponent 0xFE MSB-first (8 squares, 7 multiplies).
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_NRM0: begin
        mul_a = a0_q;
        mul_b = a0_q ^ a1_q;
      end
      S_NRM1: begin
        mul_a = a1_q;
        mul_b = a1_q;
      end
      S_NRM2: begin
        mul_a = IRRED_CST;
        mul_b = t1_q;
      end
      S_EXP: begin
        mul_a = acc_q;
        mul_b = step_q[0] ? n_q : acc_q;
      end
      S_OUT0: begin
        mul_a = a0_q ^ a1_q;
        mul_b = acc_q;
      end
      S_OUT1: begin
        mul_a = a1_q;
        mul_b = acc_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign mul_p = gf8_mul(mul_a, mul_b);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    n_d     = n_q;
    acc_d   = acc_q;
    o_d     = o_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a0_d    = i_x[7:0];
          a1_d    = i_x[15:8];
          state_d = S_NRM0;
        end
      end
      S_NRM0: begin
        t0_d    = mul_p;
        state_d = S_NRM1;
      end
      S_NRM1: begin
        t1_d    = mul_p;
        state_d = S_NRM2;
      end
      S_NRM2: begin
        n_d     = t0_q ^ mul_p;
        acc_d   = 8'h01;
        step_d  = '0;
        state_d = S_EXP;
      end
      S_EXP: begin
        acc_d = mul_p;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = S_OUT0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_OUT0: begin
        o_d[7:0] = mul_p;
        state_d  = S_OUT1;
      end
      S_OUT1: begin
        o_d[15:8] = mul_p;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
    end
  end

  assign o_o    = o_q;
  assign o_done = (state_q == S_DONE);
  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_gf_inv_16_s.sv
// Bench for gf_inv_16_s: reference inverse is x^(2^16-2) evaluated with a behavioural
// GF(2^16) multiplier, plus a product-equals-one check on every result.
module tb_gf_inv_16_s;

  localparam logic [7:0] CST = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] o;
  logic        done;
  logic        busy;

  int checks = 0;
  int failures = 0;

  gf_inv_16_s #(.IRRED_CST(CST)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_x    (x),
    .o_o    (o),
    .o_done (done),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  // Carry-less product followed by polynomial reduction by 0x11B
  function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  // (a0 + a1 X)(b0 + b1 X) with X^2 = X + c
  function automatic logic [15:0] mul16(input logic [15:0] p, input logic [15:0] q);
    logic [7:0] hh;
    hh = m8(p[15:8], q[15:8]);
    return {m8(p[7:0], q[15:8]) ^ m8(p[15:8], q[7:0]) ^ hh, m8(p[7:0], q[7:0]) ^ m8(hh, CST)};
  endfunction

  function automatic logic [15:0] inv16(input logic [15:0] v);
    logic [15:0] r;
    logic [15:0] b;
    int unsigned e;
    r = 16'h0001;
    b = v;
    e = 65534;
    while (e != 0) begin
      if (e[0]) r = mul16(r, b);
      b = mul16(b, b);
      e = e >> 1;
    end
    return r;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the first idle cycle.
  task automatic run_op(input logic [15:0] xin, output logic [15:0] res, output int lat,
                        output int nbusy, output int ndone, output logic [15:0] oo_acc);
    start = 1'b1;
    x = xin;
    @(posedge clk); #1;
    start = 1'b0;
    x = 16'($urandom);
    oo_acc = o;
    lat = -1;
    nbusy = 0;
    ndone = 0;
    res = '0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          res = o;
        end
      end
      if (!busy && n > 0) break;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    x = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o !== 16'h0000) begin failures++; $display("FAIL reset_o got=%h exp=0000", o); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy_with_start got=%b exp=0", busy); end
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [15:0] res, oo;
    int lat, nb, nd;
    run_op(16'h0001, res, lat, nb, nd, oo);
    checks++; if (res !== 16'h0001) begin failures++; $display("FAIL basic_result got=%h exp=0001", res); end
    checks++; if (lat != 20) begin failures++; $display("FAIL basic_latency got=%0d exp=20", lat); end
    checks++; if (nb != 21) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=21", nb); end
    checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", nd); end
  endtask

  task automatic test_known();
    logic [15:0] xs[3] = '{16'h0002, 16'h0003, 16'h0000};
    logic [15:0] ex[3] = '{16'h008D, 16'h00F6, 16'h0000};
    logic [15:0] prev;
    logic [15:0] res, oo;
    int lat, nb, nd;
    prev = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], res, lat, nb, nd, oo);
      checks++; if (res !== ex[i]) begin failures++; $display("FAIL known_result x=%h got=%h exp=%h", xs[i], res, ex[i]); end
      checks++; if (lat != 20) begin failures++; $display("FAIL known_latency x=%h got=%0d exp=20", xs[i], lat); end
      checks++; if (nd != 1) begin failures++; $display("FAIL known_done_pulses x=%h got=%0d exp=1", xs[i], nd); end
      checks++; if (oo !== prev) begin failures++; $display("FAIL known_hold_at_accept x=%h got=%h exp=%h", xs[i], oo, prev); end
      prev = ex[i];
    end
  endtask

  task automatic test_random();
    logic [15:0] xr, res, oo, exp_r;
    int lat, nb, nd;
    for (int i = 0; i < 1000; i++) begin
      xr = 16'($urandom_range(65535, 1));
      exp_r = inv16(xr);
      run_op(xr, res, lat, nb, nd, oo);
      checks++; if (res !== exp_r) begin failures++; $display("FAIL random_result x=%h got=%h exp=%h", xr, res, exp_r); end
      checks++; if (mul16(xr, res) !== 16'h0001) begin failures++; $display("FAIL random_product x=%h got=%h exp=0001", xr, mul16(xr, res)); end
      checks++; if (lat != 20) begin failures++; $display("FAIL random_latency x=%h got=%0d exp=20", xr, lat); end
    end
  endtask

  task automatic test_edges();
    logic [15:0] xs[3] = '{16'h0100, 16'hFFFF, 16'h8000};
    logic [15:0] res, oo, exp_r;
    int lat, nb, nd;
    for (int i = 0; i < 3; i++) begin
      exp_r = inv16(xs[i]);
      run_op(xs[i], res, lat, nb, nd, oo);
      checks++; if (res !== exp_r) begin failures++; $display("FAIL edge_result x=%h got=%h exp=%h", xs[i], res, exp_r); end
      checks++; if (mul16(xs[i], res) !== 16'h0001) begin failures++; $display("FAIL edge_product x=%h got=%h exp=0001", xs[i], mul16(xs[i], res)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r1, res, oo, exp_r;
    int nd1, dn, lat, nb, nd;
    exp_r = inv16(16'h1234);
    nd1 = 0;
    dn = -1;
    r1 = '0;
    start = 1'b1;
    x = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 21; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (done) begin
        nd1++;
        if (dn < 0) begin
          dn = n;
          r1 = o;
        end
      end
      start = (n == 5 || n == 20) && (n != 21);
      if (start) x = 16'h1234 ^ 16'($urandom_range(65535, 1));
    end
    start = 1'b0;
    checks++; if (r1 !== exp_r) begin failures++; $display("FAIL b2b_result got=%h exp=%h", r1, exp_r); end
    checks++; if (nd1 != 1) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=1", nd1); end
    checks++; if (dn != 20) begin failures++; $display("FAIL b2b_latency got=%0d exp=20", dn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_start_ignored busy got=%b exp=0", busy); end
    checks++; if (o !== exp_r) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", o, exp_r); end
    run_op(16'h0003, res, lat, nb, nd, oo);
    checks++; if (res !== 16'h00F6) begin failures++; $display("FAIL b2b_next_result got=%h exp=00f6", res); end
    checks++; if (lat != 20) begin failures++; $display("FAIL b2b_next_latency got=%0d exp=20", lat); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res, oo;
    int lat, nb, nd;
    start = 1'b1;
    x = 16'h4567;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (o !== 16'h0000) begin failures++; $display("FAIL midrst_o got=%h exp=0000", o); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    run_op(16'h0003, res, lat, nb, nd, oo);
    checks++; if (res !== 16'h00F6) begin failures++; $display("FAIL midrst_next_result got=%h exp=00f6", res); end
    checks++; if (lat != 20) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=20", lat); end
    checks++; if (nd != 1) begin failures++; $display("FAIL midrst_done_pulses got=%0d exp=1", nd); end
    checks++; if (oo !== 16'h0000) begin failures++; $display("FAIL midrst_hold_at_accept got=%h exp=0000", oo); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_known();
    test_random();
    test_edges();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
